// File: rtl/ysyx_23060191_div_unit.sv
// ysyx_23060191_div_unit
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow complete in one cycle. All other
// operations iterate WIDTH times on operand magnitudes, and the sign is
// fixed up when the result is registered.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
//   The request side uses div_valid/div_ready. The result side uses
//   res_valid/res_ready. Once raised, res_valid and res_data hold until
//   the transfer.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous abort of any in-flight operation
//   div_valid/ready request handshake
//   div_op          00=DIV 01=DIVU 10=REM 11=REMU
//   div_dividend    rs1
//   div_divisor     rs2
//   res_valid/ready result handshake
//   res_data        quotient or remainder
//   dbg_state       current FSM state (0=IDLE 1=CALC 2=DONE)
module ysyx_23060191_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] div_dividend,
  input  logic [WIDTH-1:0] div_divisor,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_rem_q;
  logic               q_sign_q;
  logic               r_sign_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvs_q;

  assign div_ready = (state == IDLE) && !flush;
  assign dbg_state = state;

  // Accept-time decode
  logic             sign_op;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             div_by_zero;
  logic             overflow;
  logic [WIDTH-1:0] fast_data;

  always_comb begin
    sign_op     = ~div_op[0];
    sa          = sign_op & div_dividend[WIDTH-1];
    sb          = sign_op & div_divisor[WIDTH-1];
    a_abs       = sa ? -div_dividend : div_dividend;
    b_abs       = sb ? -div_divisor : div_divisor;
    div_by_zero = (div_divisor == '0);
    overflow    = sign_op && (div_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                  && (div_divisor == '1);
    fast_data   = '0;
    if (div_by_zero)
      fast_data = div_op[1] ? div_dividend : '1;
    else if (overflow)
      fast_data = div_op[1] ? '0 : div_dividend;
  end

  // One restoring step. The shifted remainder needs WIDTH+1 bits because
  // rem < divisor can still have its top bit set. The trial's top bit is
  // the borrow, so a clear bit means the subtraction fits.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] final_data;

  always_comb begin
    rem_sh     = {rem_q, quo_q[WIDTH-1]};
    trial      = rem_sh - {1'b0, dvs_q};
    rem_nx     = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx     = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    final_data = is_rem_q ? (r_sign_q ? -rem_nx : rem_nx)
                          : (q_sign_q ? -quo_nx : quo_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_data  <= '0;
      cnt       <= '0;
      is_rem_q  <= 1'b0;
      q_sign_q  <= 1'b0;
      r_sign_q  <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
    end else if (flush) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid) begin
            is_rem_q <= div_op[1];
            q_sign_q <= sa ^ sb;
            r_sign_q <= sa;
            quo_q    <= a_abs;
            rem_q    <= '0;
            dvs_q    <= b_abs;
            cnt      <= '0;
            if (div_by_zero || overflow) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_data  <= fast_data;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_data  <= final_data;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_div_unit.sv
module tb_ysyx_23060191_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         flush = 1'b0;
  logic         div_valid = 1'b0;
  logic         div_ready;
  logic [1:0]   div_op = 2'd0;
  logic [W-1:0] div_dividend = '0;
  logic [W-1:0] div_divisor = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic [1:0]   dbg_state;

  ysyx_23060191_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .div_valid(div_valid), .div_ready(div_ready), .div_op(div_op),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];
  string        name_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // driver: called just after a negedge or just after an accept edge
  task automatic do_req(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                        input bit push);
    int waited = 0;
    div_valid = 1'b1;
    div_op = op;
    div_dividend = a;
    div_divisor = b;
    while (!div_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!div_ready) begin
      fail_now({name, "_accept"});
      div_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    // operands after accept must not matter
    div_valid = 1'b0;
    div_dividend = $urandom;
    div_divisor = $urandom;
    div_op = 2'($urandom_range(0, 3));
    if (push) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      acc_q.push_back(last_acc);
      name_q.push_back(name);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    @(negedge clk);
  endtask

  // monitor
  logic         prev_valid = 1'b0;
  logic [W-1:0] m_exp;
  int           m_lat;
  int           m_acc;
  string        m_name;

  always @(negedge clk) begin
    if (res_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=0x%08h expected=no_result", res_data);
      end else begin
        m_exp = exp_q.pop_front();
        m_lat = lat_q.pop_front();
        m_acc = acc_q.pop_front();
        m_name = name_q.pop_front();
        chk(m_name, res_data, m_exp);
        chk({m_name, "_latency"}, W'(cyc - m_acc + 1), W'(m_lat));
        chk({m_name, "_div_ready"}, W'(div_ready), W'(0));
        chk({m_name, "_state"}, W'(dbg_state), W'(2));
      end
    end
    prev_valid = res_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int hand_cyc;
  int n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_res_valid", W'(res_valid), W'(0));
    chk("rst_res_data", res_data, W'(0));
    chk("rst_state", W'(dbg_state), W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_div_ready", W'(div_ready), W'(1));

    // directed vectors
    do_req("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1);  wait_drain();
    do_req("remu_100_7",  OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1);   wait_drain();
    do_req("div_m7_2",    OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, 1); wait_drain();
    do_req("rem_m7_2",    OP_REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, 1); wait_drain();
    do_req("rem_7_m2",    OP_REM, 32'h7, 32'hFFFF_FFFE, 32'h1, 33, 1); wait_drain();
    do_req("div_m100_m7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hE, 33, 1); wait_drain();
    do_req("rem_m100_7",  OP_REM, 32'hFFFF_FF9C, 32'h7, 32'hFFFF_FFFE, 33, 1); wait_drain();
    do_req("div_by0",     OP_DIV, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1, 1); wait_drain();
    do_req("remu_by0",    OP_REMU, 32'h1234_5678, 32'h0, 32'h1234_5678, 1, 1); wait_drain();
    do_req("divu_max_1",  OP_DIVU, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 33, 1); wait_drain();
    do_req("div_ovf",     OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1); wait_drain();
    do_req("rem_ovf",     OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1); wait_drain();

    // backpressure, handoff, back-to-back
    res_ready = 1'b0;
    do_req("bp_divu", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33, 1);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) fail_now("bp_wait_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", W'(res_valid), W'(1));
      chk("bp_hold_data", res_data, W'(100));
      chk("bp_hold_ready", W'(div_ready), W'(0));
    end
    res_ready = 1'b1;
    @(negedge clk);
    hand_cyc = cyc;
    chk("handoff_valid", W'(res_valid), W'(0));
    chk("handoff_ready", W'(div_ready), W'(1));
    chk("handoff_data_held", res_data, W'(100));
    do_req("b2b_rem", OP_REM, 32'd50, 32'hFFFF_FFF9, 32'd1, 33, 1);
    chk("b2b_accept_cycle", W'(last_acc), W'(hand_cyc + 1));
    wait_drain();

    // flush mid-CALC
    do_req("flush_req", OP_DIVU, 32'd9, 32'd3, 32'd0, 0, 0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_ready_masked", W'(div_ready), W'(0));
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_state", W'(dbg_state), W'(0));
    chk("flush_valid", W'(res_valid), W'(0));
    chk("flush_ready", W'(div_ready), W'(1));
    repeat (40) @(negedge clk);
    do_req("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1);
    wait_drain();

    // reset mid-CALC
    do_req("rst_req", OP_DIVU, 32'd100, 32'd7, 32'd0, 0, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", W'(res_valid), W'(0));
    chk("midrst_state", W'(dbg_state), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", W'(div_ready), W'(1));
    chk("midrst_data", res_data, W'(0));
    repeat (40) @(negedge clk);
    do_req("after_rst_remu", OP_REMU, 32'hDEAD_BEEF, 32'h10, 32'hF, 33, 1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
